mem_sequencer: RTL and testbench
================================

MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, width of the memory word and of the host data buses.
REQ-002 Parameter ADDR_W, default 1, width of the memory address (2 words at the default).
REQ-003 Parameter RD_WAIT, default 1, clock cycles between driving a read address and sampling mem_dout (legal range 1-3).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  reset; synchronous, active-high.
REQ-006 Port req  input  1  host request; sampled only in IDLE.
REQ-007 Port op  input  2  command: 00 WRITE, 01 READ, 10 COPY, 11 CLEAR_ALL.
REQ-008 Port addr  input  ADDR_W  host word address.
REQ-009 Port wdata  input  DATA_W  host write data.
REQ-010 Port ack  output  1  one-cycle pulse marking command completion.
REQ-011 Port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 Port rdata  output  DATA_W  last read result; held until the next READ or COPY updates it.
REQ-013 Port err  output  1  one-cycle pulse when req is high while busy.
REQ-014 Port ops_done  output  8  count of completed commands.
REQ-015 Port mem_add  output  ADDR_W  address to the downstream memory.
REQ-016 Port mem_rw  output  1  memory write strobe; 1 = write on this rising edge, 0 = read.
REQ-017 Port mem_din  output  DATA_W  write data to the memory.
REQ-018 Port mem_dout  input  DATA_W  read data from the memory.

Function
REQ-019 The FSM SHALL have the states IDLE, WR, RD, CP_RD, CP_WR, CLR0, CLR1 and DONE.
REQ-020 When req=1 in IDLE, the block SHALL latch op, addr and wdata and move to WR, RD, CP_RD or CLR0 according to op.
REQ-021 WR SHALL drive mem_rw=1, mem_add=latched addr and mem_din=latched wdata for exactly one cycle, then move to DONE.
REQ-022 RD SHALL drive mem_rw=0 and mem_add=addr for RD_WAIT cycles, capture mem_dout into rdata on the last of those cycles, then move to DONE.
REQ-023 CP_RD SHALL perform a read as in RD; CP_WR SHALL then write the captured word to addr XOR 1 (the last address bit inverted) for one cycle, then move to DONE.
REQ-024 CLR0 SHALL write 0 to address 0 for one cycle, and CLR1 SHALL write 0 to address 1 for one cycle, then move to DONE; with ADDR_W>1 only addresses 0 and 1 are cleared.
REQ-025 DONE SHALL assert ack for one cycle, increment ops_done, and return to IDLE.
REQ-026 ops_done SHALL wrap from 255 to 0.
REQ-027 Latency from req sampled to ack high SHALL be: WRITE 2 cycles; READ RD_WAIT+1 cycles; COPY RD_WAIT+2 cycles; CLEAR_ALL 3 cycles.
REQ-028 mem_rw SHALL be 0 in every state other than WR, CP_WR, CLR0 and CLR1.
REQ-029 A req while busy SHALL be ignored, SHALL pulse err, and SHALL NOT alter the command in progress.
REQ-030 A req in the DONE cycle SHALL be ignored (busy=1); the next request is accepted in IDLE.
REQ-031 All outputs SHALL be registered.
REQ-032 mem_din SHALL be 0 whenever mem_rw=0.

Reset
REQ-033 While reset=1 at a rising edge, the block SHALL enter IDLE and clear ack, busy, err, rdata, ops_done, mem_add, mem_rw and mem_din to 0.
REQ-034 Reset mid-command SHALL abort the command with no ack, and mem_rw SHALL be 0 from the next cycle.
REQ-035 reset SHALL take priority over req in the same cycle.

Structure
REQ-036 A shared package SHALL hold the op encodings (OP_WRITE, OP_READ, OP_COPY, OP_CLEAR) and the FSM state encoding.
REQ-037 The block SHALL be a single module with one FSM and a down-counter for RD_WAIT; no sub-module is needed.
REQ-038 The bench SHALL pair the block with the existing 2x8 memory model.

Verification
REQ-039 WRITE addr=1 wdata=0x25, then READ addr=1 -> WRITE ack 2 cycles after req; READ gives rdata=0x25 with ack at RD_WAIT+1; ops_done=2.
REQ-040 WRITE addr=0 0x07, then COPY addr=0, then READ addr=1 -> rdata=0x07; word 0 still reads 0x07.
REQ-041 Memory preloaded {0x76,0x36}, then CLEAR_ALL -> mem_rw high for exactly 2 cycles (addresses 0 then 1); subsequent reads of both words return 0x00; ack 3 cycles after req.
REQ-042 req held high continuously during a COPY -> err pulses every busy cycle after acceptance; exactly one ack; the command after DONE is accepted in IDLE.
REQ-043 reset asserted in CP_RD -> no ack; busy=0 and mem_rw=0 the next cycle; word addr^1 unchanged.
REQ-044 256 back-to-back WRITEs -> ops_done wraps to 0 on the 256th ack.

Source files
------------

// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the memory sequencer: host command encodings,
// FSM state encoding and the width of the read-wait down-counter.
package mem_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_COPY  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        CP_RD = 3'd3,
        CP_WR = 3'd4,
        CLR0  = 3'd5,
        CLR1  = 3'd6,
        DONE  = 3'd7
    } state_e;

    // Enough to count down RD_WAIT values of 1..3.
    localparam int WAIT_W = 2;

endpackage

// File: rtl/mem_sequencer_if.sv
// Host command bus plus downstream memory port of the sequencer.
// master: the side that issues commands and models the memory.
// slave:  the sequencer itself.
interface mem_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 1
);
    logic              req;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              busy;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [7:0]        ops_done;
    logic [ADDR_W-1:0] mem_add;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output req, op, addr, wdata, mem_dout,
        input  ack, busy, rdata, err, ops_done, mem_add, mem_rw, mem_din
    );

    modport slave (
        input  req, op, addr, wdata, mem_dout,
        output ack, busy, rdata, err, ops_done, mem_add, mem_rw, mem_din
    );
endinterface

// File: rtl/mem_sequencer.sv
// Memory command sequencer: accepts WRITE / READ / COPY / CLEAR_ALL
// requests in IDLE and drives a simple single-port memory. Every output
// is a register loaded from the next-state decode, so memory controls
// line up exactly with the state they belong to.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 1,
    parameter int RD_WAIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_sequencer_if.slave   bus
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          ops_q, ops_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   mem_add_q, mem_add_d;
    logic                mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;

    // Next-state decode plus the registered-output values for that next state.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ops_d     = ops_q;
        mem_rw_d  = 1'b0;
        mem_add_d = '0;
        mem_din_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    case (op_e'(bus.op))
                        OP_WRITE: state_d = WR;
                        OP_READ: begin
                            state_d = RD;
                            wait_d  = WAIT_W'(RD_WAIT - 1);
                        end
                        OP_COPY: begin
                            state_d = CP_RD;
                            wait_d  = WAIT_W'(RD_WAIT - 1);
                        end
                        OP_CLEAR: state_d = CLR0;
                    endcase
                end
            end
            WR:        state_d = DONE;
            RD, CP_RD: begin
                // The last wait cycle samples the memory; COPY goes on to write it back.
                if (wait_q == '0) begin
                    rdata_d = bus.mem_dout;
                    state_d = (state_q == RD) ? DONE : CP_WR;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            CP_WR:     state_d = DONE;
            CLR0:      state_d = CLR1;
            CLR1:      state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        ack_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
        err_d  = bus.req && (state_q != IDLE);
        if (state_d == DONE) begin
            ops_d = ops_q + 8'd1;
        end

        // mem_din stays zero unless a write strobe goes with it.
        case (state_d)
            WR: begin
                mem_rw_d  = 1'b1;
                mem_add_d = addr_d;
                mem_din_d = wdata_d;
            end
            RD, CP_RD: mem_add_d = addr_d;
            CP_WR: begin
                mem_rw_d  = 1'b1;
                mem_add_d = addr_d ^ ADDR_W'(1);
                mem_din_d = rdata_d;
            end
            CLR0: begin
                mem_rw_d  = 1'b1;
                mem_add_d = '0;
            end
            CLR1: begin
                mem_rw_d  = 1'b1;
                mem_add_d = ADDR_W'(1);
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ops_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            mem_add_q <= '0;
            mem_rw_q  <= 1'b0;
            mem_din_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ops_q     <= ops_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            mem_add_q <= mem_add_d;
            mem_rw_q  <= mem_rw_d;
            mem_din_q <= mem_din_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.ops_done = ops_q;
    assign bus.mem_add  = mem_add_q;
    assign bus.mem_rw   = mem_rw_q;
    assign bus.mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer paired with a 2x8 memory model
// (write on rising edge when mem_rw=1, combinational read).
module tb_mem_sequencer;
    import mem_sequencer_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 1;
    localparam int RD_WAIT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_WAIT(RD_WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // 2x8 memory model with a backdoor preload port.
    logic [7:0] mem_q [0:1];
    logic       pre_en   = 1'b0;
    logic       pre_addr = 1'b0;
    logic [7:0] pre_data = 8'h00;

    always @(posedge clk) begin
        if (pre_en)
            mem_q[pre_addr] <= pre_data;
        else if (bus.mem_rw)
            mem_q[bus.mem_add] <= bus.mem_din;
    end
    assign bus.mem_dout = mem_q[bus.mem_add];

    int checks_cnt = 0;
    int errors_cnt = 0;
    int din_viol   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    // Issue one command, follow it to ack (bounded), then step into IDLE.
    // lat counts cycles after the accepting edge, the first one being 1.
    task automatic run_cmd(input logic [1:0] op, input logic a, input logic [7:0] d,
                           output int lat, output int rw_cycles,
                           output logic [7:0] rw_addrs, output logic [7:0] ops_at_ack);
        bus.req   = 1'b1;
        bus.op    = op;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.req    = 1'b0;
        lat        = 0;
        rw_cycles  = 0;
        rw_addrs   = 8'h00;
        ops_at_ack = 8'h00;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            if (bus.mem_rw) begin
                rw_addrs = {rw_addrs[6:0], bus.mem_add};
                rw_cycles++;
            end else if (bus.mem_din != 8'h00) begin
                din_viol++;
            end
            if (bus.ack) begin
                lat        = n;
                ops_at_ack = bus.ops_done;
            end else begin
                tick();
            end
        end
        if (lat != 0) tick();
        $display("cmd op=%0d addr=%0d wdata=0x%02h lat=%0d rw=%0d rdata=0x%02h ops=%0d",
                 op, a, d, lat, rw_cycles, bus.rdata, ops_at_ack);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, rwc, errs, acks, first_k, second_k, bad_lat;
        logic [7:0] rwa, ops, ops255, ops256;

        // Reset with a request pending: reset must win and everything clears.
        reset     = 1'b1;
        bus.req   = 1'b1;
        bus.op    = OP_WRITE;
        bus.addr  = 1'b1;
        bus.wdata = 8'hFF;
        tick();
        tick();
        check("rst_ack",      32'(bus.ack),      0);
        check("rst_busy",     32'(bus.busy),     0);
        check("rst_err",      32'(bus.err),      0);
        check("rst_rdata",    32'(bus.rdata),    0);
        check("rst_ops_done", 32'(bus.ops_done), 0);
        check("rst_mem_add",  32'(bus.mem_add),  0);
        check("rst_mem_rw",   32'(bus.mem_rw),   0);
        check("rst_mem_din",  32'(bus.mem_din),  0);
        bus.req = 1'b0;
        reset   = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.busy), 0);
        preload(1'b0, 8'h00);
        preload(1'b1, 8'h00);

        // WRITE addr1 0x25 then READ it back.
        run_cmd(OP_WRITE, 1'b1, 8'h25, lat, rwc, rwa, ops);
        check("wr_lat",     32'(lat), 2);
        check("wr_rw_cnt",  32'(rwc), 1);
        check("wr_rw_addr", 32'(rwa), 1);
        check("wr_mem1",    32'(mem_q[1]), 32'h25);
        run_cmd(OP_READ, 1'b1, 8'h00, lat, rwc, rwa, ops);
        check("rd_lat",   32'(lat), RD_WAIT + 1);
        check("rd_rw",    32'(rwc), 0);
        check("rd_rdata", 32'(bus.rdata), 32'h25);
        check("rd_ops",   32'(ops), 2);

        // WRITE addr0 0x07, COPY addr0 -> addr1, read both words.
        run_cmd(OP_WRITE, 1'b0, 8'h07, lat, rwc, rwa, ops);
        check("wr0_lat", 32'(lat), 2);
        run_cmd(OP_COPY, 1'b0, 8'hEE, lat, rwc, rwa, ops);
        check("cp_lat",     32'(lat), RD_WAIT + 2);
        check("cp_rw_cnt",  32'(rwc), 1);
        check("cp_rw_addr", 32'(rwa), 1);
        check("cp_mem1",    32'(mem_q[1]), 32'h07);
        run_cmd(OP_READ, 1'b1, 8'h00, lat, rwc, rwa, ops);
        check("cp_rd1", 32'(bus.rdata), 32'h07);
        run_cmd(OP_READ, 1'b0, 8'h00, lat, rwc, rwa, ops);
        check("cp_rd0", 32'(bus.rdata), 32'h07);
        check("cp_ops", 32'(ops), 6);

        // CLEAR_ALL over preloaded {0x76,0x36}: two write cycles, addr 0 then 1.
        preload(1'b0, 8'h76);
        preload(1'b1, 8'h36);
        run_cmd(OP_CLEAR, 1'b1, 8'hAA, lat, rwc, rwa, ops);
        check("clr_lat",      32'(lat), 3);
        check("clr_rw_cnt",   32'(rwc), 2);
        check("clr_rw_addrs", 32'(rwa), 32'h01);
        run_cmd(OP_READ, 1'b0, 8'h00, lat, rwc, rwa, ops);
        check("clr_rd0", 32'(bus.rdata), 0);
        run_cmd(OP_READ, 1'b1, 8'h00, lat, rwc, rwa, ops);
        check("clr_rd1", 32'(bus.rdata), 0);
        check("clr_ops", 32'(ops), 9);

        // req held high through a COPY; a READ queued behind it lands in IDLE.
        preload(1'b0, 8'h5A);
        preload(1'b1, 8'h00);
        bus.req   = 1'b1;
        bus.op    = OP_COPY;
        bus.addr  = 1'b0;
        bus.wdata = 8'h00;
        tick();
        errs = 0; acks = 0; first_k = 0; second_k = 0;
        for (int k = 1; k <= 14; k++) begin
            if (bus.err) errs++;
            if (bus.ack) begin
                acks++;
                if (first_k == 0) begin
                    first_k  = k;
                    bus.op   = OP_READ;
                    bus.addr = 1'b1;
                end else if (second_k == 0) begin
                    second_k = k;
                end
            end
            if (first_k != 0 && k == first_k + 2) bus.req = 1'b0;
            tick();
        end
        bus.req = 1'b0;
        $display("cmd op=%0d addr=0 held-req errs=%0d acks=%0d ack_at=%0d,%0d rdata=0x%02h",
                 OP_COPY, errs, acks, first_k, second_k, bus.rdata);
        check("held_err_cnt",  32'(errs), RD_WAIT + 2);
        check("held_ack_cnt",  32'(acks), 2);
        check("held_cp_ack",   32'(first_k), RD_WAIT + 2);
        check("held_rd_ack",   32'(second_k), 2 * RD_WAIT + 4);
        check("held_mem1",     32'(mem_q[1]), 32'h5A);
        check("held_rdata",    32'(bus.rdata), 32'h5A);
        check("held_ops",      32'(bus.ops_done), 11);

        // Reset while in CP_RD: command aborted, target word untouched.
        preload(1'b0, 8'h11);
        preload(1'b1, 8'h22);
        bus.req  = 1'b1;
        bus.op   = OP_COPY;
        bus.addr = 1'b0;
        tick();
        bus.req = 1'b0;
        check("abort_busy_pre", 32'(bus.busy), 1);
        reset = 1'b1;
        tick();
        check("abort_busy",   32'(bus.busy),   0);
        check("abort_mem_rw", 32'(bus.mem_rw), 0);
        check("abort_ack",    32'(bus.ack),    0);
        reset = 1'b0;
        acks  = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.ack) acks++;
            tick();
        end
        $display("cmd op=%0d addr=0 aborted acks=%0d mem1=0x%02h", OP_COPY, acks, mem_q[1]);
        check("abort_no_ack", 32'(acks), 0);
        check("abort_mem1",   32'(mem_q[1]), 32'h22);

        // 256 back-to-back WRITEs: ops_done wraps to 0 on the last ack.
        bad_lat = 0;
        ops255  = 8'h00;
        ops256  = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            run_cmd(OP_WRITE, i[0], i[7:0], lat, rwc, rwa, ops);
            if (lat != 2) bad_lat++;
            if (i == 254) ops255 = ops;
            if (i == 255) ops256 = ops;
        end
        check("wrap_lat",    32'(bad_lat), 0);
        check("wrap_ops255", 32'(ops255), 255);
        check("wrap_ops256", 32'(ops256), 0);
        check("wrap_mem0",   32'(mem_q[0]), 32'hFE);
        check("wrap_mem1",   32'(mem_q[1]), 32'hFF);

        check("mem_din_zero_without_rw", 32'(din_viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
